// File: rtl/int_arbiter.sv
// External interrupt arbiter: synchronizes peripheral lines, tracks each source through
// IDLE/PENDING/IN_SERVICE, and registers the highest-priority eligible source as the request.
module int_arbiter #(
   parameter int NUM_SRC = 8,
   parameter int PRIO_W  = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_i,
   input  logic               we_i,
   input  logic [31:0]        addr_i,
   input  logic [31:0]        data_i,
   output logic [31:0]        data_o,
   output logic [7:0]         int_flag_o
);

   localparam int INT_BUS = 8;

   localparam logic [7:0] ADDR_PENDING   = 8'h00;
   localparam logic [7:0] ADDR_ENABLE    = 8'h04;
   localparam logic [7:0] ADDR_THRESHOLD = 8'h08;
   localparam logic [7:0] ADDR_CLAIM     = 8'h0C;
   localparam logic [7:0] ADDR_COMPLETE  = 8'h10;
   localparam logic [7:0] ADDR_INSERVICE = 8'h14;

   typedef enum logic [1:0] {
      GW_IDLE       = 2'd0,
      GW_PENDING    = 2'd1,
      GW_IN_SERVICE = 2'd2
   } gw_state_t;

   logic [NUM_SRC-1:0]        sync1_reg;
   logic [NUM_SRC-1:0]        lvl_reg;
   logic [NUM_SRC-1:0]        enable_reg;
   logic [PRIO_W-1:0]         threshold_reg;
   logic [NUM_SRC*PRIO_W-1:0] prio_flat;
   logic [NUM_SRC-1:0]        pending;
   logic [NUM_SRC-1:0]        in_service;
   logic [NUM_SRC-1:0]        eligible;
   logic [4:0]                best_id_q;
   logic [4:0]                best_id_next;
   logic [PRIO_W-1:0]         best_prio;
   logic                      flag_reg;
   logic [7:0]                offset;
   logic                      claim_wr;
   logic                      complete_wr;
   logic                      unused_addr;

   assign offset      = addr_i[7:0];
   assign unused_addr = ^addr_i[31:8];
   assign claim_wr    = we_i && (offset == ADDR_CLAIM);
   assign complete_wr = we_i && (offset == ADDR_COMPLETE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_reg <= '0;
         lvl_reg   <= '0;
      end else begin
         sync1_reg <= src_i;
         lvl_reg   <= sync1_reg;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         enable_reg    <= '0;
         threshold_reg <= '0;
      end else if (we_i) begin
         if (offset == ADDR_ENABLE)    enable_reg    <= data_i[NUM_SRC-1:0];
         if (offset == ADDR_THRESHOLD) threshold_reg <= data_i[PRIO_W-1:0];
      end
   end

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      // IDs are compared against the full data word, so 0x102 never aliases ID 2
      localparam logic [31:0] SRC_ID    = 32'(gi + 1);
      localparam logic [7:0]  PRIO_ADDR = 8'(32 + 4 * gi);

      gw_state_t         state_reg;
      gw_state_t         state_next;
      logic [PRIO_W-1:0] prio_reg;

      always_comb begin
         state_next = state_reg;
         case (state_reg)
            GW_IDLE:       if (lvl_reg[gi]) state_next = GW_PENDING;
            GW_PENDING:    if (claim_wr && data_i == SRC_ID) state_next = GW_IN_SERVICE;
            GW_IN_SERVICE: if (complete_wr && data_i == SRC_ID) state_next = GW_IDLE;
            default:       state_next = GW_IDLE;
         endcase
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state_reg <= GW_IDLE;
            prio_reg  <= '0;
         end else begin
            state_reg <= state_next;
            if (we_i && offset == PRIO_ADDR) prio_reg <= data_i[PRIO_W-1:0];
         end
      end

      assign prio_flat[gi*PRIO_W +: PRIO_W] = prio_reg;
      assign pending[gi]    = (state_reg == GW_PENDING);
      assign in_service[gi] = (state_reg == GW_IN_SERVICE);
      assign eligible[gi]   = pending[gi] && enable_reg[gi] && (prio_reg > threshold_reg);
   end

   // Strict greater-than while scanning upward keeps the lowest ID on equal priority
   always_comb begin
      best_id_next = '0;
      best_prio    = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (eligible[k] && prio_flat[k*PRIO_W +: PRIO_W] > best_prio) begin
            best_prio    = prio_flat[k*PRIO_W +: PRIO_W];
            best_id_next = 5'(k + 1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         best_id_q <= '0;
         flag_reg  <= 1'b0;
      end else begin
         best_id_q <= best_id_next;
         flag_reg  <= (best_id_next != '0);
      end
   end

   assign int_flag_o = {{(INT_BUS-1){1'b0}}, flag_reg};

   always_comb begin
      data_o = '0;
      case (offset)
         ADDR_PENDING:   data_o = 32'(pending);
         ADDR_ENABLE:    data_o = 32'(enable_reg);
         ADDR_THRESHOLD: data_o = 32'(threshold_reg);
         ADDR_CLAIM:     data_o = 32'(best_id_q);
         ADDR_INSERVICE: data_o = 32'(in_service);
         default:        data_o = '0;
      endcase
      for (int k = 0; k < NUM_SRC; k++) begin
         if (offset == 8'(32 + 4 * k)) data_o = 32'(prio_flat[k*PRIO_W +: PRIO_W]);
      end
   end

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter: directed timing scenarios plus randomized
// claim sequences checked against a priority-rule reference model.
module tb_int_arbiter;
   localparam int NUM_SRC = 8;
   localparam int PRIO_W  = 3;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [NUM_SRC-1:0] src_i = '0;
   logic               we_i = 1'b0;
   logic [31:0]        addr_i = '0;
   logic [31:0]        data_i = '0;
   logic [31:0]        data_o;
   logic [7:0]         int_flag_o;

   int cmp_count  = 0;
   int fail_count = 0;

   logic [PRIO_W-1:0]  m_prio [NUM_SRC];
   logic [NUM_SRC-1:0] m_en;
   logic [NUM_SRC-1:0] m_pend;
   logic [NUM_SRC-1:0] m_insv;
   logic [PRIO_W-1:0]  m_thr;

   always #5 clk = ~clk;

   int_arbiter #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .src_i      (src_i),
      .we_i       (we_i),
      .addr_i     (addr_i),
      .data_i     (data_i),
      .data_o     (data_o),
      .int_flag_o (int_flag_o)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
      addr_i = {24'h0, a};
      data_i = d;
      we_i   = 1'b1;
      @(posedge clk);
      #1;
      we_i = 1'b0;
      $display("wr addr=0x%02h data=0x%0h", a, d);
   endtask

   task automatic read_reg(input logic [7:0] a, output logic [31:0] d);
      we_i   = 1'b0;
      addr_i = {24'h0, a};
      #1;
      d = data_o;
   endtask

   task automatic do_reset();
      src_i = '0;
      we_i  = 1'b0;
      rst   = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(1);
   endtask

   // Reference: among eligible sources find the top priority, then the lowest ID holding it
   function automatic int model_best();
      int cand[$];
      int top;
      top = 0;
      for (int k = 0; k < NUM_SRC; k++)
         if (m_pend[k] && m_en[k] && m_prio[k] > m_thr) cand.push_back(k + 1);
      foreach (cand[i]) if (int'(m_prio[cand[i]-1]) > top) top = int'(m_prio[cand[i]-1]);
      foreach (cand[i]) if (int'(m_prio[cand[i]-1]) == top) return cand[i];
      return 0;
   endfunction

   task automatic test_reset();
      logic [31:0] d;
      rst = 1'b0;
      tick(1);
      cmp_count++;
      if (int_flag_o !== 8'h00) begin fail_count++; $display("FAIL reset_flag: got 0x%02h expected 0x00", int_flag_o); end
      read_reg(8'h04, d);
      cmp_count++;
      if (d !== 32'h0) begin fail_count++; $display("FAIL reset_enable: got 0x%0h expected 0x0", d); end
      read_reg(8'h0C, d);
      cmp_count++;
      if (d !== 32'h0) begin fail_count++; $display("FAIL reset_claim: got 0x%0h expected 0x0", d); end
      read_reg(8'h08, d);
      cmp_count++;
      if (d !== 32'h0) begin fail_count++; $display("FAIL reset_threshold: got 0x%0h expected 0x0", d); end
      read_reg(8'h20, d);
      cmp_count++;
      if (d !== 32'h0) begin fail_count++; $display("FAIL reset_prio0: got 0x%0h expected 0x0", d); end
      rst = 1'b1;
      tick(1);
      $display("test_reset done");
   endtask

   task automatic test_single_source();
      logic [31:0] d;
      do_reset();
      write_reg(8'h28, 32'd3);
      write_reg(8'h04, 32'h04);
      write_reg(8'h08, 32'd0);
      src_i[2] = 1'b1;
      for (int e = 0; e < 3; e++) begin
         tick(1);
         cmp_count++;
         if (int_flag_o !== 8'h00) begin fail_count++; $display("FAIL single_early_flag E%0d: got 0x%02h expected 0x00", e, int_flag_o); end
      end
      read_reg(8'h00, d);
      cmp_count++;
      if (d !== 32'h04) begin fail_count++; $display("FAIL single_pending_E2: got 0x%0h expected 0x4", d); end
      tick(1);
      cmp_count++;
      if (int_flag_o !== 8'h01) begin fail_count++; $display("FAIL single_flag_E3: got 0x%02h expected 0x01", int_flag_o); end
      read_reg(8'h0C, d);
      cmp_count++;
      if (d !== 32'd3) begin fail_count++; $display("FAIL single_claim_read: got %0d expected 3", d); end
      write_reg(8'h0C, 32'd3);
      read_reg(8'h14, d);
      cmp_count++;
      if (d !== 32'h04) begin fail_count++; $display("FAIL single_inservice: got 0x%0h expected 0x4", d); end
      cmp_count++;
      if (int_flag_o !== 8'h01) begin fail_count++; $display("FAIL single_flag_at_C: got 0x%02h expected 0x01", int_flag_o); end
      tick(1);
      cmp_count++;
      if (int_flag_o !== 8'h00) begin fail_count++; $display("FAIL single_flag_C1: got 0x%02h expected 0x00", int_flag_o); end
      $display("test_single_source done");
   endtask

   task automatic test_priority_tie();
      logic [31:0] d;
      int exp_seq[4] = '{6, 7, 2, 0};
      do_reset();
      write_reg(8'h24, 32'd2);
      write_reg(8'h34, 32'd5);
      write_reg(8'h38, 32'd5);
      write_reg(8'h04, 32'h62);
      src_i = 8'h62;
      tick(4);
      for (int i = 0; i < 4; i++) begin
         read_reg(8'h0C, d);
         cmp_count++;
         if (d !== 32'(exp_seq[i])) begin fail_count++; $display("FAIL tie_claim_%0d: got %0d expected %0d", i, d, exp_seq[i]); end
         if (i < 3) begin
            write_reg(8'h0C, 32'(exp_seq[i]));
            tick(1);
         end
      end
      read_reg(8'h14, d);
      cmp_count++;
      if (d !== 32'h62) begin fail_count++; $display("FAIL tie_inservice: got 0x%0h expected 0x62", d); end
      $display("test_priority_tie done");
   endtask

   task automatic test_threshold_enable();
      logic [31:0] d;
      do_reset();
      write_reg(8'h20, 32'd2);
      write_reg(8'h08, 32'd2);
      write_reg(8'h04, 32'h01);
      src_i[0] = 1'b1;
      tick(4);
      cmp_count++;
      if (int_flag_o !== 8'h00) begin fail_count++; $display("FAIL thr_blocked_flag: got 0x%02h expected 0x00", int_flag_o); end
      read_reg(8'h00, d);
      cmp_count++;
      if (d !== 32'h01) begin fail_count++; $display("FAIL thr_pending: got 0x%0h expected 0x1", d); end
      write_reg(8'h08, 32'd1);
      cmp_count++;
      if (int_flag_o !== 8'h00) begin fail_count++; $display("FAIL thr_flag_at_W: got 0x%02h expected 0x00", int_flag_o); end
      tick(1);
      cmp_count++;
      if (int_flag_o !== 8'h01) begin fail_count++; $display("FAIL thr_flag_W1: got 0x%02h expected 0x01", int_flag_o); end
      write_reg(8'h04, 32'h00);
      tick(1);
      cmp_count++;
      if (int_flag_o !== 8'h00) begin fail_count++; $display("FAIL en_off_flag: got 0x%02h expected 0x00", int_flag_o); end
      read_reg(8'h00, d);
      cmp_count++;
      if (d !== 32'h01) begin fail_count++; $display("FAIL en_off_pending: got 0x%0h expected 0x1", d); end
      write_reg(8'h04, 32'h01);
      tick(1);
      cmp_count++;
      if (int_flag_o !== 8'h01) begin fail_count++; $display("FAIL en_on_flag: got 0x%02h expected 0x01", int_flag_o); end
      $display("test_threshold_enable done");
   endtask

   task automatic test_bad_claim();
      logic [31:0] d;
      logic [7:0]  bad_addr[6] = '{8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h10, 8'h00};
      logic [31:0] bad_data[6] = '{32'd0, 32'd9, 32'd5, 32'h102, 32'd2, 32'hFF};
      do_reset();
      write_reg(8'h24, 32'd1);
      write_reg(8'h04, 32'h02);
      src_i[1] = 1'b1;
      tick(4);
      for (int i = 0; i < 6; i++) begin
         write_reg(bad_addr[i], bad_data[i]);
         tick(1);
         read_reg(8'h00, d);
         cmp_count++;
         if (d !== 32'h02) begin fail_count++; $display("FAIL bad_%0d_pending: got 0x%0h expected 0x2", i, d); end
         read_reg(8'h14, d);
         cmp_count++;
         if (d !== 32'h00) begin fail_count++; $display("FAIL bad_%0d_inservice: got 0x%0h expected 0x0", i, d); end
      end
      read_reg(8'h0C, d);
      cmp_count++;
      if (d !== 32'd2) begin fail_count++; $display("FAIL bad_claim_read: got %0d expected 2", d); end
      read_reg(8'h18, d);
      cmp_count++;
      if (d !== 32'h0) begin fail_count++; $display("FAIL unmapped_read: got 0x%0h expected 0x0", d); end
      write_reg(8'h0C, 32'd2);
      write_reg(8'h10, 32'd5);
      read_reg(8'h14, d);
      cmp_count++;
      if (d !== 32'h02) begin fail_count++; $display("FAIL bad_complete_other: got 0x%0h expected 0x2", d); end
      read_reg(8'h10, d);
      cmp_count++;
      if (d !== 32'h0) begin fail_count++; $display("FAIL complete_read: got 0x%0h expected 0x0", d); end
      $display("test_bad_claim done");
   endtask

   task automatic test_retrigger();
      logic [31:0] d;
      do_reset();
      write_reg(8'h2C, 32'd4);
      write_reg(8'h04, 32'h08);
      src_i[3] = 1'b1;
      tick(4);
      write_reg(8'h0C, 32'd4);
      tick(1);
      cmp_count++;
      if (int_flag_o !== 8'h00) begin fail_count++; $display("FAIL retrig_claimed_flag: got 0x%02h expected 0x00", int_flag_o); end
      write_reg(8'h10, 32'd4);
      read_reg(8'h00, d);
      cmp_count++;
      if (d !== 32'h00) begin fail_count++; $display("FAIL retrig_pending_D: got 0x%0h expected 0x0", d); end
      read_reg(8'h14, d);
      cmp_count++;
      if (d !== 32'h00) begin fail_count++; $display("FAIL retrig_inservice_D: got 0x%0h expected 0x0", d); end
      tick(1);
      read_reg(8'h00, d);
      cmp_count++;
      if (d !== 32'h08) begin fail_count++; $display("FAIL retrig_pending_D1: got 0x%0h expected 0x8", d); end
      cmp_count++;
      if (int_flag_o !== 8'h00) begin fail_count++; $display("FAIL retrig_flag_D1: got 0x%02h expected 0x00", int_flag_o); end
      tick(1);
      cmp_count++;
      if (int_flag_o !== 8'h01) begin fail_count++; $display("FAIL retrig_flag_D2: got 0x%02h expected 0x01", int_flag_o); end
      $display("test_retrigger done");
   endtask

   task automatic test_async_reset();
      logic [31:0] d;
      do_reset();
      write_reg(8'h20, 32'd1);
      write_reg(8'h24, 32'd1);
      write_reg(8'h04, 32'hFF);
      src_i = 8'h03;
      tick(4);
      write_reg(8'h0C, 32'd1);
      tick(1);
      read_reg(8'h14, d);
      cmp_count++;
      if (d !== 32'h01) begin fail_count++; $display("FAIL ares_pre_inservice: got 0x%0h expected 0x1", d); end
      cmp_count++;
      if (int_flag_o !== 8'h01) begin fail_count++; $display("FAIL ares_pre_flag: got 0x%02h expected 0x01", int_flag_o); end
      rst = 1'b0;
      #1;
      cmp_count++;
      if (int_flag_o !== 8'h00) begin fail_count++; $display("FAIL ares_flag: got 0x%02h expected 0x00", int_flag_o); end
      read_reg(8'h14, d);
      cmp_count++;
      if (d !== 32'h0) begin fail_count++; $display("FAIL ares_inservice: got 0x%0h expected 0x0", d); end
      read_reg(8'h04, d);
      cmp_count++;
      if (d !== 32'h0) begin fail_count++; $display("FAIL ares_enable: got 0x%0h expected 0x0", d); end
      src_i = '0;
      tick(1);
      rst = 1'b1;
      tick(1);
      $display("test_async_reset done");
   endtask

   task automatic test_random();
      logic [31:0] d;
      int exp_id;
      for (int it = 0; it < 8; it++) begin
         do_reset();
         for (int k = 0; k < NUM_SRC; k++) begin
            m_prio[k] = PRIO_W'($urandom_range(0, 7));
            write_reg(8'(32 + 4 * k), 32'(m_prio[k]));
         end
         m_en  = NUM_SRC'($urandom_range(0, 255));
         m_thr = PRIO_W'($urandom_range(0, 3));
         write_reg(8'h04, 32'(m_en));
         write_reg(8'h08, 32'(m_thr));
         m_pend = NUM_SRC'($urandom_range(1, 255));
         m_insv = '0;
         src_i  = m_pend;
         tick(4);
         read_reg(8'h00, d);
         cmp_count++;
         if (d !== 32'(m_pend)) begin fail_count++; $display("FAIL rnd%0d_pending: got 0x%0h expected 0x%0h", it, d, m_pend); end
         for (int r = 0; r < NUM_SRC + 1; r++) begin
            exp_id = model_best();
            read_reg(8'h0C, d);
            cmp_count++;
            if (d !== 32'(exp_id)) begin fail_count++; $display("FAIL rnd%0d_claim%0d: got %0d expected %0d", it, r, d, exp_id); end
            cmp_count++;
            if (int_flag_o[0] !== (exp_id != 0)) begin fail_count++; $display("FAIL rnd%0d_flag%0d: got %0b expected %0b", it, r, int_flag_o[0], exp_id != 0); end
            if (exp_id == 0) break;
            write_reg(8'h0C, 32'(exp_id));
            m_pend[exp_id-1] = 1'b0;
            m_insv[exp_id-1] = 1'b1;
            tick(1);
            read_reg(8'h14, d);
            cmp_count++;
            if (d !== 32'(m_insv)) begin fail_count++; $display("FAIL rnd%0d_insv%0d: got 0x%0h expected 0x%0h", it, r, d, m_insv); end
         end
         m_en  = '1;
         m_thr = '0;
         write_reg(8'h04, 32'hFF);
         write_reg(8'h08, 32'h0);
         tick(1);
         exp_id = model_best();
         read_reg(8'h0C, d);
         cmp_count++;
         if (d !== 32'(exp_id)) begin fail_count++; $display("FAIL rnd%0d_open_claim: got %0d expected %0d", it, d, exp_id); end
      end
      $display("test_random done");
   endtask

   initial begin
      #2;
      test_reset();
      test_single_source();
      test_priority_tie();
      test_threshold_enable();
      test_bad_claim();
      test_retrigger();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
      $finish;
   end

endmodule
